multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 266 ++++++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//
// Single-issue integer execution unit with a valid/ready request side and a
// valid/ready result side. Simple ALU ops and illegal codes finish one cycle
// after acceptance. Multiply/divide ops run a radix-2 shift-add / restoring
// divide loop for exactly XLEN cycles.
//
// Optional feature macro: MULTICYCLE_ALU_MDU_EN
//   defined   -> ops 16-23 (MUL..REMU) are implemented using the BUSY state
//   undefined -> no multiply/divide logic; ops 16-23 complete as illegal
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     request present
//   in_ready     unit idle and able to accept a request
//   op           operation code (0-9 ALU, 16-23 MDU, others illegal)
//   a, b         operands
//   branch       request is a conditional-branch compare
//   branch_type  funct3 branch condition
//   out_valid    result available
//   out_ready    consumer takes the result
//   result       operation result
//   sel_branch   branch taken
//   illegal_op   accepted op code was illegal or compiled out
// -----------------------------------------------------------------------------
module multicycle_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            branch,
  input  logic [2:0]      branch_type,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            sel_branch,
  output logic            illegal_op
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_XOR  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;

`ifdef MULTICYCLE_ALU_MDU_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_e;
`endif

  state_e state_q, state_d;

  logic            accept;
  logic [XLEN-1:0] result_q;
  logic            sel_q;
  logic            illegal_q;

  // Outputs are gated by rst so they read as zero for the whole reset
  // window, including the first cycle before the state register is cleared.
  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE) && !rst;
  assign result     = rst ? '0 : result_q;
  assign sel_branch = sel_q && !rst;
  assign illegal_op = illegal_q && !rst;

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU and branch compare, evaluated on the request operands
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] alu_res;
  logic            alu_illegal;
  logic            take;
  logic            sel_next;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;
  assign eq    = a == b;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      default: alu_illegal = 1'b1;
    endcase
  end

  // funct3 010/011 are not branch conditions and never take.
  always_comb begin
    take = 1'b0;
    case (branch_type)
      3'b000:  take = eq;
      3'b001:  take = !eq;
      3'b100:  take = lt_s;
      3'b101:  take = !lt_s;
      3'b110:  take = lt_u;
      3'b111:  take = !lt_u;
      default: take = 1'b0;
    endcase
  end

  assign sel_next = branch && take;

`ifdef MULTICYCLE_ALU_MDU_EN
  // ---------------------------------------------------------------------------
  // Multiply/divide iteration. Both loops work on operand magnitudes and fix
  // the sign afterwards. acc holds {high, low}: for multiply the partial
  // product shifts in from the top while the multiplier drains from the
  // bottom; for divide it is {remainder, dividend/quotient}.
  // ---------------------------------------------------------------------------
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  logic              is_mdu;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2:0]        fn_q;
  logic              a_neg_q, b_neg_q, b_zero_q;
  logic [XLEN-1:0]   a_q, opnd_q;
  logic [SHW-1:0]    cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_next, prod;
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   quot, rem, mdu_res;

  assign is_mdu = (op[4:3] == 2'b10);

  // fn: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
  assign a_signed = (op[2:0] == 3'd1) || (op[2:0] == 3'd2) ||
                    (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
  assign b_signed = (op[2:0] == 3'd1) || (op[2:0] == 3'd4) ||
                    (op[2:0] == 3'd6);
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  // NOTE: pure datapath registers carry no reset; they are always loaded on
  // acceptance before anything reads them, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (accept && is_mdu) begin
      fn_q     <= op[2:0];
      a_q      <= a;
      a_neg_q  <= a_neg;
      b_neg_q  <= b_neg;
      b_zero_q <= (b == '0);
      acc_q    <= {{XLEN{1'b0}}, a_mag};
      opnd_q   <= b_mag;
      cnt_q    <= '0;
    end else if (state_q == BUSY) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q + SHW'(1);
    end
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    acc_next  = {mul_sum, acc_q[XLEN-1:1]};
    if (fn_q[2]) begin
      // Restoring step: subtract only when it does not go negative.
      acc_next[2*XLEN-1:XLEN] = div_ge ? XLEN'(div_shift - {1'b0, opnd_q})
                                       : div_shift[XLEN-1:0];
      acc_next[XLEN-1:0]      = {acc_q[XLEN-2:0], div_ge};
    end
  end

  // Final result is taken from acc_next so the last iteration and the
  // write-back share one edge.
  always_comb begin
    mdu_res = '0;
    prod    = (a_neg_q ^ b_neg_q) ? -acc_next : acc_next;
    quot    = acc_next[XLEN-1:0];
    rem     = acc_next[2*XLEN-1:XLEN];
    case (fn_q)
      3'd0:                 mdu_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:     mdu_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:           mdu_res = b_zero_q ? '1
                                    : ((a_neg_q ^ b_neg_q) ? -quot : quot);
      default:              mdu_res = b_zero_q ? a_q : (a_neg_q ? -rem : rem);
    endcase
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MULTICYCLE_ALU_MDU_EN
          state_d = is_mdu ? BUSY : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MULTICYCLE_ALU_MDU_EN
      BUSY:    if (cnt_q == CNT_LAST) state_d = DONE;
`endif
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers only change on acceptance or MDU completion, so they
  // hold steady through DONE under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      sel_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      sel_q     <= sel_next;
      result_q  <= alu_res;
      illegal_q <= alu_illegal;
`ifdef MULTICYCLE_ALU_MDU_EN
      if (is_mdu) illegal_q <= 1'b0;
`endif
    end
`ifdef MULTICYCLE_ALU_MDU_EN
    else if (state_q == BUSY && cnt_q == CNT_LAST) begin
      result_q <= mdu_res;
    end
`endif
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_alu
//
// Scoreboard bench for multicycle_alu (XLEN = 32). A driver issues requests
// and pushes the expected response; a monitor pops and compares whenever the
// DUT presents a result. Expected values come from a reference model using
// plain 64-bit arithmetic, or from literal values for directed cases.
// Follows MULTICYCLE_ALU_MDU_EN to decide whether ops 16-23 are implemented.
// -----------------------------------------------------------------------------
module tb_multicycle_alu;

  localparam int XLEN = 32;
`ifdef MULTICYCLE_ALU_MDU_EN
  localparam int MDU_LAT = XLEN + 1;
`endif

  typedef struct {
    logic [31:0] res;
    logic        sel;
    logic        ill;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        branch = 1'b0;
  logic [2:0]  branch_type = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        sel_branch;
  logic        illegal_op;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   pops  = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  bit   head_seen = 1'b0;
  exp_t scb[$];

  multicycle_alu #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .branch      (branch),
    .branch_type (branch_type),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .sel_branch  (sel_branch),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic s, input logic il, input int lat);
    exp_t e;
    e.res = r; e.sel = s; e.ill = il; e.lat = lat; e.acc_cyc = 0;
    return e;
  endfunction

  // Reference model: architectural meaning of each op in plain arithmetic.
  function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic br, input logic [2:0] bt);
    exp_t        e;
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    logic        tk;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    e = mk(32'h0, 1'b0, 1'b0, 1);
    case (o)
      5'd0: e.res = x + y;
      5'd1: e.res = x - y;
      5'd2: e.res = x ^ y;
      5'd3: e.res = x | y;
      5'd4: e.res = x & y;
      5'd5: e.res = x << y[4:0];
      5'd6: e.res = x >> y[4:0];
      5'd7: begin p = sx >>> y[4:0]; e.res = p[31:0]; end
      5'd8: e.res = (sx < sy) ? 32'd1 : 32'd0;
      5'd9: e.res = (x < y) ? 32'd1 : 32'd0;
`ifdef MULTICYCLE_ALU_MDU_EN
      5'd16: begin p = ux * uy; e.res = p[31:0];  e.lat = MDU_LAT; end
      5'd17: begin p = sx * sy; e.res = p[63:32]; e.lat = MDU_LAT; end
      5'd18: begin p = sx * uy; e.res = p[63:32]; e.lat = MDU_LAT; end
      5'd19: begin p = ux * uy; e.res = p[63:32]; e.lat = MDU_LAT; end
      5'd20: begin
        e.lat = MDU_LAT;
        if (y == 0) e.res = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) e.res = x;
        else begin p = sx / sy; e.res = p[31:0]; end
      end
      5'd21: begin e.lat = MDU_LAT; e.res = (y == 0) ? 32'hFFFF_FFFF : x / y; end
      5'd22: begin
        e.lat = MDU_LAT;
        if (y == 0) e.res = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) e.res = 32'h0;
        else begin p = sx % sy; e.res = p[31:0]; end
      end
      5'd23: begin e.lat = MDU_LAT; e.res = (y == 0) ? x : x % y; end
`endif
      default: begin e.res = 32'h0; e.ill = 1'b1; end
    endcase
    case (bt)
      3'b000:  tk = (x == y);
      3'b001:  tk = (x != y);
      3'b100:  tk = (sx < sy);
      3'b101:  tk = !(sx < sy);
      3'b110:  tk = (x < y);
      3'b111:  tk = !(x < y);
      default: tk = 1'b0;
    endcase
    e.sel = br && tk;
    return e;
  endfunction

  // Expected value for an MDU op in whichever build is compiled.
  function automatic exp_t mdu_exp(input logic [31:0] r);
`ifdef MULTICYCLE_ALU_MDU_EN
    return mk(r, 1'b0, 1'b0, XLEN + 1);
`else
    return mk(32'h0, 1'b0, 1'b1, 1);
`endif
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compares the head of the scoreboard whenever a result is shown.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (scb.size() == 0) begin
        check("spurious_output", out_ready, 1'b0);
      end else begin
        if (!head_seen) begin
          check("latency", cyc - scb[0].acc_cyc, scb[0].lat);
          head_seen = 1'b1;
        end
        check("in_ready_in_done", in_ready, 1'b0);
        if (out_ready) begin
          check("result", result, scb[0].res);
          check("sel_branch", sel_branch, scb[0].sel);
          check("illegal_op", illegal_op, scb[0].ill);
          void'(scb.pop_front());
          head_seen = 1'b0;
          pops++;
        end else begin
          check("result_held", result, scb[0].res);
        end
      end
    end
  end

  task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic br, input logic [2:0] bt, input bit expect_it, input exp_t e);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; op = o; a = x; b = y; branch = br; branch_type = bt;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      check("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    if (expect_it) begin
      e.acc_cyc = cyc;
      scb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && scb.size() != 0; i++) @(negedge clk);
    check("drain", scb.size(), 0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_result"}, result, 32'h0);
    check({tag, "_sel_branch"}, sel_branch, 1'b0);
    check({tag, "_illegal_op"}, illegal_op, 1'b0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  o;
    logic [31:0] x, y;
    logic        br;
    logic [2:0]  bt;
    int          r, p0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1'b1);

    // Directed cases with literal expectations
    send(5'd0, 32'd5, 32'd7, 1'b0, 3'b000, 1'b1, mk(32'd12, 1'b0, 1'b0, 1));
    send(5'd7, 32'h8000_0000, 32'd4, 1'b0, 3'b000, 1'b1, mk(32'hF800_0000, 1'b0, 1'b0, 1));
    send(5'd6, 32'h8000_0000, 32'd4, 1'b0, 3'b000, 1'b1, mk(32'h0800_0000, 1'b0, 1'b0, 1));
    send(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 3'b100, 1'b1, mk(32'hFFFF_FFFE, 1'b1, 1'b0, 1));
    send(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 3'b110, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1));
    send(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 3'b001, 1'b1, mk(32'hFFFF_FFFE, 1'b1, 1'b0, 1));
    send(5'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 3'b010, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1));
    send(5'd17, 32'h8000_0000, 32'h8000_0000, 1'b0, 3'b000, 1'b1, mdu_exp(32'h4000_0000));
    send(5'd20, 32'd7, 32'd0, 1'b0, 3'b000, 1'b1, mdu_exp(32'hFFFF_FFFF));
    send(5'd22, 32'd7, 32'd0, 1'b0, 3'b000, 1'b1, mdu_exp(32'd7));
    send(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'b000, 1'b1, mdu_exp(32'h8000_0000));
    send(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'b000, 1'b1, mdu_exp(32'h0));
    send(5'd20, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'b000, 1'b1, mdu_exp(32'hFFFF_FFFD));
    send(5'd22, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'b000, 1'b1, mdu_exp(32'hFFFF_FFFF));
    send(5'd31, 32'd9, 32'd3, 1'b0, 3'b000, 1'b1, mk(32'h0, 1'b0, 1'b1, 1));
    wait_drain();

    // Backpressure: hold out_ready low for 5 cycles in DONE, then one handshake
    ready_mode = 2;
    @(posedge clk);
    send(5'd0, 32'd3, 32'd4, 1'b1, 3'b000, 1'b1, mk(32'd7, 1'b0, 1'b0, 1));
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    p0 = pops;
    ready_mode = 0;
    wait_drain();
    check("one_handshake", pops - p0, 1);

    // Randomized traffic against the reference model
    ready_mode = 1;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 19);
      if (r < 10)       o = 5'(r);
      else if (r < 18)  o = 5'(16 + r - 10);
      else if (r == 18) o = 5'($urandom_range(10, 15));
      else              o = 5'($urandom_range(24, 31));
      x  = rnd_val();
      y  = rnd_val();
      br = 1'($urandom_range(0, 1));
      bt = 3'($urandom_range(0, 7));
      send(o, x, y, br, bt, 1'b1, model(o, x, y, br, bt));
    end
    ready_mode = 0;
    wait_drain();

    // Reset in the middle of a DIV: no output may appear
    ready_mode = 2;
    @(posedge clk);
    send(5'd20, 32'd1000, 32'd7, 1'b0, 3'b000, 1'b0, mk(32'h0, 1'b0, 1'b0, 1));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
`ifdef MULTICYCLE_ALU_MDU_EN
      check("busy_no_out_valid", out_valid, 1'b0);
`endif
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_abort", in_ready, 1'b1);
    check("out_valid_after_abort", out_valid, 1'b0);
    ready_mode = 0;
    repeat (40) @(negedge clk);

    send(5'd31, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 3'b000, 1'b1, mk(32'h0, 1'b0, 1'b1, 1));
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
